// File: rtl/parking_occupancy_counter_if.sv
// Sensor inputs and display/status outputs of the parking occupancy counter.
// The slave modport is the counter side and the master modport is the gate/display side.
`timescale 1ns/1ps
interface parking_occupancy_counter_if;
  logic       sensor_a;
  logic       sensor_b;
  logic [3:0] hex3;
  logic [3:0] hex2;
  logic [3:0] hex1;
  logic [3:0] hex0;
  logic [3:0] dp_in;
  logic       full;
  logic       empty;
  logic       enter_tick;
  logic       exit_tick;
  logic       err_tick;

  modport master (
    output sensor_a, sensor_b,
    input  hex3, hex2, hex1, hex0, dp_in, full, empty, enter_tick, exit_tick, err_tick
  );

  modport slave (
    input  sensor_a, sensor_b,
    output hex3, hex2, hex1, hex0, dp_in, full, empty, enter_tick, exit_tick, err_tick
  );
endinterface

// File: rtl/parking_occupancy_counter.sv
// Two-beam gate occupancy counter with a 4-digit BCD count and display feed.
// Define PARK_DEBOUNCE_EN to add a DB_CYCLES-long stability filter on each synchronized sensor.
`timescale 1ns/1ps
module parking_occupancy_counter #(
  parameter int unsigned CAPACITY  = 50,
  parameter logic [19:0] DB_CYCLES = 20'd1000000
) (
  input  logic                        clk,
  input  logic                        reset,
  parking_occupancy_counter_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3} state_t;

  localparam logic [15:0] CAP_BCD = {4'(CAPACITY / 1000 % 10), 4'(CAPACITY / 100 % 10),
                                     4'(CAPACITY / 10 % 10), 4'(CAPACITY % 10)};

  if (CAPACITY < 1 || CAPACITY > 9999 || DB_CYCLES == 20'd0) begin : g_param_check
    $error("parking_occupancy_counter: CAPACITY must be 1..9999 and DB_CYCLES nonzero");
  end

  logic        a_meta, a_sync, b_meta, b_sync;
  logic [1:0]  s;
  state_t      state, state_next;
  logic        entry_evt, exit_evt;
  logic [15:0] count;
  logic        at_full, at_empty;
  logic        enter_q, exit_q, err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_meta <= 1'b0;
      a_sync <= 1'b0;
      b_meta <= 1'b0;
      b_sync <= 1'b0;
    end else begin
      a_meta <= bus.sensor_a;
      a_sync <= a_meta;
      b_meta <= bus.sensor_b;
      b_sync <= b_meta;
    end
  end

`ifdef PARK_DEBOUNCE_EN
  logic        a_stable, b_stable;
  logic [19:0] a_cnt, b_cnt;

  // A sensor's filtered value only follows the synchronized one after DB_CYCLES unbroken cycles of disagreement.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_stable <= 1'b0;
      b_stable <= 1'b0;
      a_cnt    <= '0;
      b_cnt    <= '0;
    end else begin
      if (a_sync == a_stable) begin
        a_cnt <= '0;
      end else if (a_cnt == DB_CYCLES - 20'd1) begin
        a_stable <= a_sync;
        a_cnt    <= '0;
      end else begin
        a_cnt <= a_cnt + 20'd1;
      end
      if (b_sync == b_stable) begin
        b_cnt <= '0;
      end else if (b_cnt == DB_CYCLES - 20'd1) begin
        b_stable <= b_sync;
        b_cnt    <= '0;
      end else begin
        b_cnt <= b_cnt + 20'd1;
      end
    end
  end

  assign s = {a_stable, b_stable};
`else
  assign s = {a_sync, b_sync};
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Exit states mirror entry with the two beams swapped; any non-adjacent pattern aborts to IDLE.
  always_comb begin
    state_next = IDLE;
    unique case (state)
      IDLE: begin
        if (s == 2'b10)      state_next = EN1;
        else if (s == 2'b01) state_next = EX1;
        else                 state_next = IDLE;
      end
      EN1: begin
        if (s == 2'b11)      state_next = EN2;
        else if (s == 2'b10) state_next = EN1;
      end
      EN2: begin
        if (s == 2'b01)      state_next = EN3;
        else if (s == 2'b10) state_next = EN1;
        else if (s == 2'b11) state_next = EN2;
      end
      EN3: begin
        if (s == 2'b11)      state_next = EN2;
        else if (s == 2'b01) state_next = EN3;
      end
      EX1: begin
        if (s == 2'b11)      state_next = EX2;
        else if (s == 2'b01) state_next = EX1;
      end
      EX2: begin
        if (s == 2'b10)      state_next = EX3;
        else if (s == 2'b01) state_next = EX1;
        else if (s == 2'b11) state_next = EX2;
      end
      EX3: begin
        if (s == 2'b11)      state_next = EX2;
        else if (s == 2'b10) state_next = EX3;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    entry_evt = (state == EN3) && (s == 2'b00);
    exit_evt  = (state == EX3) && (s == 2'b00);
  end

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign at_full  = (count == CAP_BCD);
  assign at_empty = (count == 16'h0000);

  // Count and ticks update on the same edge the FSM falls back to IDLE after a completed pass.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count   <= 16'h0000;
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
      err_q   <= 1'b0;
      if (entry_evt) begin
        if (!at_full) begin
          count   <= bcd_inc(count);
          enter_q <= 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end else if (exit_evt) begin
        if (!at_empty) begin
          count  <= bcd_dec(count);
          exit_q <= 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.hex3       = count[15:12];
  assign bus.hex2       = count[11:8];
  assign bus.hex1       = count[7:4];
  assign bus.hex0       = count[3:0];
  assign bus.full       = at_full;
  assign bus.empty      = at_empty;
  assign bus.dp_in      = at_full ? 4'b1110 : 4'b1111;
  assign bus.enter_tick = enter_q;
  assign bus.exit_tick  = exit_q;
  assign bus.err_tick   = err_q;

endmodule

// File: doc/parking_occupancy_counter.md
PARKING_OCCUPANCY_COUNTER -- requirements
Module: parking_occupancy_counter

Interface
REQ-001 Parameter CAPACITY, default 50, lot capacity in cars (legal range 1..9999).
REQ-002 Parameter DB_CYCLES, default 20'd1000000, debounce stability window in clk cycles (used only with PARK_DEBOUNCE_EN).
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-005 sensor_a  input  1  outer photo sensor, 1 = beam blocked, asynchronous to clk.
REQ-006 sensor_b  input  1  inner photo sensor, 1 = beam blocked, asynchronous to clk.
REQ-007 hex3, hex2, hex1, hex0  output  4 each  BCD occupancy digits, thousands..units, direct feed to the 4-digit display multiplexer.
REQ-008 dp_in  output  4  decimal points for the display multiplexer, active-low (0 = lit).
REQ-009 full  output  1  high while occupancy == CAPACITY.
REQ-010 empty  output  1  high while occupancy == 0.
REQ-011 enter_tick, exit_tick  output  1 each  one-cycle pulse per counted entry / exit.
REQ-012 err_tick  output  1  one-cycle pulse when an entry at full or an exit at empty is rejected.

Function
REQ-013 sensor_a and sensor_b SHALL each pass through a 2-flop synchronizer; the FSM sees input pair s = {a_sync, b_sync}.
REQ-014 FSM states: IDLE, EN1, EN2, EN3, EX1, EX2, EX3; all registered.
REQ-015 IDLE: s=10 -> EN1; s=01 -> EX1; otherwise stay.
REQ-016 EN1: 11 -> EN2; 10 stay; 00 or 01 -> IDLE. EN2: 01 -> EN3; 10 -> EN1; 11 stay; 00 -> IDLE. EN3: 00 -> IDLE with entry event; 11 -> EN2; 01 stay; 10 -> IDLE.
REQ-017 Exit path SHALL mirror entry with a and b swapped (EX1 on 01, EX2 on 11, EX3 on 10, exit event on EX3 -> IDLE via 00).
REQ-018 Entry event with occupancy < CAPACITY: occupancy +1 and enter_tick high, both on the same edge as the FSM returns to IDLE.
REQ-019 Exit event with occupancy > 0: occupancy -1 and exit_tick high, both on the same edge.
REQ-020 Entry event at full, or exit event at empty: occupancy held, err_tick high for one cycle, no enter_tick/exit_tick.
REQ-021 Occupancy SHALL be held as 4 BCD digits; increment and decrement SHALL ripple carry/borrow across digits (e.g. 0099 -> 0100, 0100 -> 0099); no digit ever exceeds 9.
REQ-022 hex3..hex0 SHALL be registered copies of the BCD digits, updating on the same edge as the count.
REQ-023 full and empty SHALL be combinational compares of the registered count.
REQ-024 dp_in SHALL be 4'b1110 while full (units decimal point lit as FULL indicator), otherwise 4'b1111.
REQ-025 Aborted or illegal sequences (car backs out, any non-adjacent jump) SHALL return to IDLE without a count change.
REQ-026 Latency: a sensor change reaches the FSM 2 cycles after it is sampled (plus the debounce window when enabled).

Reset
REQ-027 reset low at a clock edge: FSM -> IDLE; count = 0000; hex3..hex0 = 0; dp_in = 4'b1111; enter_tick = exit_tick = err_tick = 0; synchronizer and debounce registers cleared.
REQ-028 reset asserted mid-sequence SHALL discard the partial sequence; no event is generated for it after release.

Configuration
REQ-029 Macro PARK_DEBOUNCE_EN defined: each synchronized sensor SHALL feed the FSM only after holding a new value for DB_CYCLES consecutive cycles; shorter glitches are ignored.
REQ-030 PARK_DEBOUNCE_EN undefined: the synchronized sensors feed the FSM directly; DB_CYCLES is unused.

Verification
REQ-031 Reset, then s sequence 00,10,11,01,00 (each held 4 cycles) -> one enter_tick, hex0=1, empty=0.
REQ-032 From occupancy 1, s sequence 01,11,10,00 -> one exit_tick, count 0000, empty=1.
REQ-033 CAPACITY=50, preload 49 entries, 1 more entry -> count 0050, full=1, dp_in=4'b1110; a further entry -> err_tick, count stays 0050.
REQ-034 From empty, full exit sequence -> err_tick pulse, count 0000, no exit_tick.
REQ-035 Sequence 10,11,10,00 (back-out) -> no ticks, count unchanged; reset low during EN2 -> IDLE, count 0000.
REQ-036 With PARK_DEBOUNCE_EN and DB_CYCLES=8: 3-cycle glitch on sensor_a -> no state change; full entry sequence with 10-cycle holds -> one enter_tick.
